// File: rtl/condicionador_pkg.sv
// condicionador_pkg
// Shared definitions for the input-conditioning stage placed in front of
// jogo_desafio_memoria: button-FSM state encodings, the default debounce
// length and a one-hot test used to validate button presses.
package condicionador_pkg;

  // 5 ms at the 1 MHz board clock.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 5000;

  // Encodings are visible on db_estado, so they are fixed explicitly.
  typedef enum logic [2:0] {
    OCIOSO        = 3'b000,
    FILTRA        = 3'b001,
    EMITE         = 3'b010,
    REJEITA       = 3'b011,
    ESPERA_SOLTAR = 3'b100,
    SOLTA         = 3'b101
  } estado_t;

  // True when exactly one of the four bits is set.
  function automatic logic one_hot4(input logic [3:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit
// Single-bit debouncer. The output level follows the (already synchronized)
// input only after DEBOUNCE_CYCLES consecutive cycles of a value that differs
// from the current output.
// Ports:
//   clock  in  system clock, rising edge
//   reset  in  asynchronous active-high reset (q and counter cleared)
//   d      in  synchronized input bit
//   q      out debounced level
module debounce_bit
  import condicionador_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // cnt counts how many cycles d has disagreed with q; any agreement
  // restarts the run, so only an unbroken run flips the level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (d == q) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      q   <= d;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/condicionador_entradas.sv
// condicionador_entradas
// Synchronizes, debounces and validates the raw button and start pins for
// the memory game FSM. A clean single-button press yields one jogada_feita
// pulse and a held one-hot jogada code; a stable multi-button press yields a
// multipla pulse instead. A debounced rising edge of jogar yields iniciar.
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-high reset, clears every flop
//   botoes[3:0]  in   raw button pins (1 = pressed)
//   jogar        in   raw start pin (1 = pressed)
//   jogada_feita out  one-cycle pulse per validated single-button press
//   jogada[3:0]  out  one-hot code of the last valid press (held)
//   multipla     out  one-cycle pulse per stable multi-button press
//   iniciar      out  one-cycle pulse per debounced jogar press
//   db_estado    out  current button-FSM state encoding
module condicionador_entradas
  import condicionador_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       jogar,
  output logic       jogada_feita,
  output logic [3:0] jogada,
  output logic       multipla,
  output logic       iniciar,
  output logic [2:0] db_estado
);

  localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchronizers.
  logic [3:0] b_meta, b_s;
  logic       j_meta, j_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      b_meta <= '0;
      b_s    <= '0;
      j_meta <= 1'b0;
      j_s    <= 1'b0;
    end else begin
      b_meta <= botoes;
      b_s    <= b_meta;
      j_meta <= jogar;
      j_s    <= j_meta;
    end
  end

  // Start path: debounced level, then a registered rising-edge detector.
  logic jogar_nivel, jogar_nivel_d;

  debounce_bit #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce_jogar (
    .clock(clock),
    .reset(reset),
    .d    (j_s),
    .q    (jogar_nivel)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jogar_nivel_d <= 1'b0;
      iniciar       <= 1'b0;
    end else begin
      jogar_nivel_d <= jogar_nivel;
      iniciar       <= jogar_nivel & ~jogar_nivel_d;
    end
  end

  // Button FSM.
  estado_t       estado, prox_estado;
  logic [CW-1:0] cnt, cnt_next;
  logic [3:0]    amostra, amostra_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado  <= OCIOSO;
      cnt     <= '0;
      amostra <= '0;
    end else begin
      estado  <= prox_estado;
      cnt     <= cnt_next;
      amostra <= amostra_next;
    end
  end

  always_comb begin
    prox_estado  = estado;
    cnt_next     = cnt;
    amostra_next = amostra;
    case (estado)
      OCIOSO: begin
        if (b_s != '0) begin
          amostra_next = b_s;
          cnt_next     = '0;
          prox_estado  = FILTRA;
        end
      end
      FILTRA: begin
        if (b_s == '0) begin
          cnt_next    = '0;
          prox_estado = OCIOSO;
        end else if (b_s != amostra) begin
          // A different combination restarts the stability window.
          amostra_next = b_s;
          cnt_next     = '0;
        end else if (cnt == CNT_MAX) begin
          cnt_next    = '0;
          prox_estado = one_hot4(amostra) ? EMITE : REJEITA;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      EMITE, REJEITA: begin
        cnt_next    = '0;
        prox_estado = ESPERA_SOLTAR;
      end
      ESPERA_SOLTAR: begin
        if (b_s == '0) begin
          cnt_next    = '0;
          prox_estado = SOLTA;
        end
      end
      SOLTA: begin
        if (b_s != '0) begin
          cnt_next    = '0;
          prox_estado = ESPERA_SOLTAR;
        end else if (cnt == CNT_MAX) begin
          cnt_next    = '0;
          prox_estado = OCIOSO;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        cnt_next    = '0;
        prox_estado = OCIOSO;
      end
    endcase
  end

  // Held code of the last accepted press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jogada <= '0;
    end else if (estado == EMITE) begin
      jogada <= amostra;
    end
  end

  assign jogada_feita = (estado == EMITE);
  assign multipla     = (estado == REJEITA);
  assign db_estado    = estado;

endmodule

// File: tb/tb_condicionador_entradas.sv
// tb_condicionador_entradas
// Self-checking bench for condicionador_entradas with DEBOUNCE_CYCLES = 4.
// A behavioural model tracks run lengths of the synchronized inputs and
// predicts every output each cycle; directed scenarios add event counts and
// latency checks, followed by randomized button/jogar/reset traffic.
module tb_condicionador_entradas;

  localparam int unsigned D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] botoes = '0;
  logic       jogar = 1'b0;
  logic       jogada_feita, multipla, iniciar;
  logic [3:0] jogada;
  logic [2:0] db_estado;

  condicionador_entradas #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .botoes      (botoes),
    .jogar       (jogar),
    .jogada_feita(jogada_feita),
    .jogada      (jogada),
    .multipla    (multipla),
    .iniciar     (iniciar),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Buttons: in the armed phase, D+1 consecutive identical non-zero samples
  // make a press (valid if one-hot). The following cycle is the output cycle,
  // after which D+1 consecutive zero samples are needed to re-arm.
  typedef enum {M_ARMED, M_OUT, M_REL} fase_t;
  fase_t       fase = M_ARMED;
  int unsigned run = 0, zrun = 0, jrun = 0;
  logic [3:0]  val = '0, r1 = '0, r2 = '0, bs;
  logic        j1 = 0, j2 = 0, js, lvl = 0, ini_pend = 0;
  logic        exp_jf = 0, exp_mult = 0, exp_ini = 0;
  logic [3:0]  exp_jogada = '0;
  logic [2:0]  exp_estado = '0;

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      fase = M_ARMED; run = 0; zrun = 0; jrun = 0; val = '0;
      r1 = '0; r2 = '0; j1 = 0; j2 = 0; lvl = 0; ini_pend = 0;
      exp_jf = 0; exp_mult = 0; exp_ini = 0; exp_jogada = '0; exp_estado = '0;
    end else begin
      // Two-cycle synchronizer delay.
      bs = r2; r2 = r1; r1 = botoes;
      js = j2; j2 = j1; j1 = jogar;
      // jogar: level flips after D consecutive differing samples; iniciar
      // appears one cycle after a 0->1 flip.
      exp_ini  = ini_pend;
      ini_pend = 0;
      if (js != lvl) begin
        jrun++;
        if (jrun == D) begin lvl = js; jrun = 0; ini_pend = js; end
      end else jrun = 0;
      exp_jf = 0; exp_mult = 0;
      case (fase)
        M_ARMED: begin
          if (bs == '0) run = 0;
          else if (run > 0 && bs == val) run++;
          else begin val = bs; run = 1; end
          if (run == D + 1) begin
            fase = M_OUT;
            if ($countones(val) == 1) exp_jf = 1; else exp_mult = 1;
          end
        end
        M_OUT: begin
          if ($countones(val) == 1) exp_jogada = val;
          fase = M_REL; zrun = 0;
        end
        default: begin
          if (bs == '0) zrun++; else zrun = 0;
          if (zrun == D + 1) begin fase = M_ARMED; run = 0; end
        end
      endcase
      case (fase)
        M_ARMED: exp_estado = (run == 0) ? 3'd0 : 3'd1;
        M_OUT:   exp_estado = ($countones(val) == 1) ? 3'd2 : 3'd3;
        default: exp_estado = (zrun == 0) ? 3'd4 : 3'd5;
      endcase
    end
  end

  // ---------------- per-cycle checker ----------------
  int jf_seen = 0, mult_seen = 0, ini_seen = 0;

  initial forever begin
    @(negedge clock);
    chk("jogada_feita", 32'(jogada_feita), 32'(exp_jf));
    chk("multipla", 32'(multipla), 32'(exp_mult));
    chk("iniciar", 32'(iniciar), 32'(exp_ini));
    chk("jogada", 32'(jogada), 32'(exp_jogada));
    chk("db_estado", 32'(db_estado), 32'(exp_estado));
    if (jogada_feita) jf_seen++;
    if (multipla) mult_seen++;
    if (iniciar) ini_seen++;
  end

  // ---------------- stimulus ----------------
  // All driving happens 1 time unit after a falling edge.
  task automatic hold(input logic [3:0] b, input logic j, input int n);
    botoes = b;
    jogar  = j;
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clock);
    #1;
    reset = 1'b0;
  endtask

  int n0, m0, i0;

  initial begin
    // Reset held for 3 cycles.
    #1;
    do_reset(3);
    hold(4'b0000, 0, 1);
    chk("rst_jogada_feita", 32'(jogada_feita), 32'd0);
    chk("rst_jogada", 32'(jogada), 32'd0);
    chk("rst_multipla", 32'(multipla), 32'd0);
    chk("rst_iniciar", 32'(iniciar), 32'd0);
    chk("rst_db_estado", 32'(db_estado), 32'd0);

    // Clean press: pulse exactly 6 cycles after the first sampling edge.
    n0 = jf_seen;
    hold(4'b0100, 0, 6);
    chk("lat_before", 32'(jogada_feita), 32'd0);
    hold(4'b0100, 0, 1);
    chk("lat_pulse", 32'(jogada_feita), 32'd1);
    hold(4'b0100, 0, 13);
    chk("clean_count", 32'(jf_seen - n0), 32'd1);
    chk("clean_jogada", 32'(jogada), 32'b0100);

    // Bounce, then stable 0001.
    hold(4'b0000, 0, 10);
    n0 = jf_seen;
    for (int i = 0; i < 5; i++) hold((i % 2 == 0) ? 4'b0001 : 4'b0000, 0, 2);
    chk("bounce_none", 32'(jf_seen - n0), 32'd0);
    chk("bounce_old_code", 32'(jogada), 32'b0100);
    hold(4'b0001, 0, 15);
    chk("bounce_count", 32'(jf_seen - n0), 32'd1);
    chk("bounce_jogada", 32'(jogada), 32'b0001);

    // Multiple buttons.
    hold(4'b0000, 0, 10);
    n0 = jf_seen; m0 = mult_seen;
    hold(4'b0011, 0, 15);
    chk("multi_mult", 32'(mult_seen - m0), 32'd1);
    chk("multi_nojf", 32'(jf_seen - n0), 32'd0);
    chk("multi_jogada", 32'(jogada), 32'b0001);

    // Release glitch.
    hold(4'b0000, 0, 10);
    n0 = jf_seen;
    hold(4'b1000, 0, 10);
    hold(4'b0000, 0, 2);
    hold(4'b1000, 0, 10);
    chk("glitch_single", 32'(jf_seen - n0), 32'd1);
    hold(4'b0000, 0, 10);
    hold(4'b1000, 0, 10);
    chk("glitch_repress", 32'(jf_seen - n0), 32'd2);
    chk("glitch_jogada", 32'(jogada), 32'b1000);

    // jogar, then reset while the button FSM is filtering.
    hold(4'b0000, 0, 10);
    i0 = ini_seen; n0 = jf_seen;
    hold(4'b0000, 1, 10);
    hold(4'b0000, 0, 8);
    chk("jogar_once", 32'(ini_seen - i0), 32'd1);
    hold(4'b0010, 0, 4);
    chk("in_filtra", 32'(db_estado), 32'd1);
    botoes = 4'b0000;
    do_reset(2);
    hold(4'b0000, 0, 12);
    chk("no_stale_jf", 32'(jf_seen - n0), 32'd0);
    chk("post_rst_estado", 32'(db_estado), 32'd0);

    // Button still held through a reset counts as a new press.
    n0 = jf_seen;
    hold(4'b0100, 0, 4);
    do_reset(2);
    hold(4'b0100, 0, 12);
    chk("held_rst_count", 32'(jf_seen - n0), 32'd1);
    chk("held_rst_jogada", 32'(jogada), 32'b0100);
    hold(4'b0000, 0, 10);

    // Randomized traffic.
    for (int s = 0; s < 300; s++) begin
      logic [3:0] b;
      logic       j;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)      b = 4'b0000;
      else if (sel < 8) b = 4'b0001 << $urandom_range(0, 3);
      else              b = 4'($urandom_range(1, 15));
      j = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 59) == 0) do_reset(int'($urandom_range(1, 3)));
      hold(b, j, int'($urandom_range(1, 12)));
    end
    hold(4'b0000, 0, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
